pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Sequences the PC register and instruction-memory fetch for the 5-stage MIPS core.
- Computes pc_next each cycle and runs the req/gnt/rvalid handshake to instruction memory.
- Buffers a returned instruction while decode is stalled, and hands instructions to the IF/ID register.
- Applies branch and exception redirects (exception > branch), kills stale fetches, and captures the EPC.

Parameters:
RESET_PC, 32'hBFC0_0000, pc_next value while in reset; must equal the PC register's default.
EXC_VECTOR, 32'hBFC0_0380, redirect target on exc_req.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-high reset (PC register is reset by ~rst at top level)
pc  input  32  current PC from the PC register
pc_4  input  32  pc + 4 from the PC register
pc_next  output  32  next PC, loaded by the PC register every cycle
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, equal to pc
imem_gnt  input  1  request accepted
imem_rvalid  input  1  read data valid; earliest one cycle after gnt; exactly one per gnt
imem_rdata  input  32  instruction word
id_stall  input  1  IF/ID must hold; no instruction may be delivered this cycle
br_taken  input  1  branch/jump resolved taken this cycle
br_target  input  32  branch/jump target
exc_req  input  1  exception taken this cycle
exc_pc  input  32  PC of the faulting instruction
if_valid  output  1  instruction delivered this cycle; IF/ID captures on the next edge
if_instr  output  32  delivered instruction
if_pc  output  32  PC of the delivered instruction
if_flush  output  1  clear IF/ID this cycle
epc  output  32  captured exception PC

Behaviour:
- State register: IDLE, FETCH, WAIT, HOLD. Other registers: kill flag, pending target (32 bits), buffered instruction (32 bits), epc.
- While rst=1:
  - State=IDLE; kill=0; buffer=0; epc=0.
  - pc_next=RESET_PC; imem_req=0; if_valid=0; if_instr=0; if_pc=0; if_flush=0.
- Redirect: redir = exc_req | br_taken; target = EXC_VECTOR if exc_req, else br_target.
- All redirect, flush and epc capture actions are ignored in IDLE.
- if_flush = redir (combinational), except in IDLE.
- epc <= exc_pc on any cycle with exc_req=1 (not in IDLE).
- Default outputs: pc_next=pc; imem_req=0; if_valid=0; if_instr=0; if_pc=0.
- IDLE:
  - Lasts exactly one cycle after rst deasserts, then -> FETCH.
- FETCH:
  - imem_req=1; imem_addr=pc.
  - gnt=1, no redir: -> WAIT.
  - gnt=1 with redir: kill=1, pending=target, pc_next=pc; -> WAIT. The granted fetch is stale.
  - gnt=0 with redir: pc_next=target; stay FETCH. imem tolerates an address change before gnt.
  - gnt=0, no redir: stay FETCH.
- WAIT:
  - imem_req=0.
  - redir while rvalid=0: kill=1, pending=target. A later redir overwrites pending; the newest wins, with exception priority within a cycle.
  - rvalid=1 with redir: discard data; pc_next=target; kill=0; -> FETCH.
  - rvalid=1 with kill=1 and no redir: discard data; pc_next=pending; kill=0; -> FETCH.
  - rvalid=1, no kill, id_stall=0: if_valid=1, if_instr=imem_rdata, if_pc=pc, pc_next=pc_4; -> FETCH.
  - rvalid=1, no kill, id_stall=1: buffer=imem_rdata; -> HOLD.
- HOLD:
  - redir: drop buffer; pc_next=target; -> FETCH.
  - id_stall=0: if_valid=1, if_instr=buffer, if_pc=pc, pc_next=pc_4; -> FETCH.
  - Otherwise hold.
- if_valid is never asserted in a cycle with redir or id_stall=1.
- Peak throughput: 1 instruction per 2 cycles (FETCH, then WAIT with rvalid on the next cycle).
- Reset asserted mid-fetch aborts the fetch immediately. A post-reset rvalid from the aborted fetch is not guarded and is an integration error.
- All PC arithmetic is modulo 2^32; pc_4 wraps 32'hFFFF_FFFC -> 0 with no special handling.

Test Plan:
- Reset release, then gnt every FETCH and rvalid the next cycle with rdata=32'h2408_0001 -> first imem_addr=BFC0_0000; if_valid on the rvalid cycle with if_pc=BFC0_0000; next imem_addr=BFC0_0004.
- id_stall=1 for 3 cycles starting at rvalid -> state HOLD; if_valid=0 and pc_next=pc throughout; on stall release, if_valid=1 with the buffered word and pc_next=pc+4.
- br_taken with br_target=BFC0_0100 while in WAIT, rvalid 2 cycles later -> returned data discarded, if_valid=0, if_flush=1 on the branch cycle; next imem_addr=BFC0_0100.
- exc_req with exc_pc=BFC0_0040 and br_taken in the same FETCH cycle, gnt=0 -> pc_next=BFC0_0380; epc=BFC0_0040 on the next cycle.
- rst asserted while in WAIT -> all outputs 0, pc_next=BFC0_0000 immediately (asynchronous); one IDLE cycle after release, then FETCH at BFC0_0000.
- pc=FFFF_FFFC fetch delivered -> pc_next=0000_0000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencing and instruction-memory fetch control for the
// 5-stage MIPS core. Runs the req/gnt/rvalid handshake, buffers a returned
// word across decode stalls, applies exception/branch redirects and kills
// fetches made stale by a redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc_4,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_flush,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;     // outstanding fetch is stale, drop its data
  logic [31:0] pend_q, pend_d;     // where to go once the stale fetch returns
  logic [31:0] buf_q, buf_d;       // word returned while decode was stalled
  logic [31:0] epc_q, epc_d;

  logic        redir;
  logic [31:0] target;

  // Exception outranks branch within a cycle.
  assign redir     = exc_req | br_taken;
  assign target    = exc_req ? EXC_VECTOR : br_target;
  assign imem_addr = pc;
  assign epc       = epc_q;

  // Next-state and combinational outputs; reset overrides everything.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    pend_d   = pend_q;
    buf_d    = buf_q;
    epc_d    = epc_q;
    pc_next  = pc;
    imem_req = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    if_flush = 1'b0;

    if (state_q != S_IDLE) begin
      if_flush = redir;
      if (exc_req) epc_d = exc_pc;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
          // Granted address is already committed; remember the redirect.
          if (redir) begin
            kill_d = 1'b1;
            pend_d = target;
          end
        end else if (redir) begin
          // Not yet granted, so the address can simply be swapped.
          pc_next = target;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_FETCH;
          kill_d  = 1'b0;
          if (redir) begin
            pc_next = target;
          end else if (kill_q) begin
            pc_next = pend_q;
          end else if (!id_stall) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = pc;
            pc_next  = pc_4;
          end else begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redir) begin
          // Newest redirect wins if several arrive while waiting.
          kill_d = 1'b1;
          pend_d = target;
        end
      end

      S_HOLD: begin
        if (redir) begin
          buf_d   = 32'h0;
          pc_next = target;
          state_d = S_FETCH;
        end else if (!id_stall) begin
          if_valid = 1'b1;
          if_instr = buf_q;
          if_pc    = pc;
          pc_next  = pc_4;
          state_d  = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      pc_next  = RESET_PC;
      imem_req = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'h0;
      if_pc    = 32'h0;
      if_flush = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any in-flight fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      pend_q  <= 32'h0;
      buf_q   <= 32'h0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      epc_q   <= epc_d;
    end
  end

endmodule
